int_ctrl_4src: RTL and testbench

INT_CTRL_4SRC -- requirements
Module: int_ctrl_4src

---
 rtl/int_ctrl_pkg.sv | 22 ++
 rtl/int_prio_enc4.sv | 22 ++
 rtl/int_ctrl_4src.sv | 164 ++++++++++++++++
 tb/tb_int_ctrl_4src.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the 4-source interrupt controller.
package int_ctrl_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  localparam logic [NUM_SRC-1:0] MASK_RESET = 4'b1111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_REQ     = 2'b01;
  localparam state_t ST_SERVICE = 2'b10;

  function automatic logic [NUM_SRC-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_SRC-1:0] oh;
    oh     = 4'b0000;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/int_prio_enc4.sv
// Fixed-priority encoder: reports whether any request bit is set and the lowest set index.
module int_prio_enc4
  import int_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  // OR-reduce and pick the lowest-index active request
  always_comb begin
    any = |req;
    casez (req)
      4'b???1: id = 2'd0;
      4'b??10: id = 2'd1;
      4'b?100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
  end

endmodule

// File: rtl/int_ctrl_4src.sv
// Four-source edge-triggered interrupt controller with mask, pending and a non-nesting request FSM.
// Optional input synchronizer: define INT_CTRL_SYNC_EN to add a 2-flop stage on Irq_In.
module int_ctrl_4src
  import int_ctrl_pkg::*;
#(
  parameter logic [NUM_SRC-1:0] SRC_POLARITY = 4'b0000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] Irq_In,
  input  logic               Mask_Wr,
  input  logic [NUM_SRC-1:0] Mask_Data,
  input  logic               Int_Ack,
  input  logic               Int_Ret,
  output logic               Irq_Req,
  output logic [ID_W-1:0]    Irq_Id,
  output logic               In_Service,
  output logic [NUM_SRC-1:0] Pending,
  output logic [NUM_SRC-1:0] Mask
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] real_s;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] prev_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] pending_nxt_s;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] active_s;
  logic               enc_any_s;
  logic [ID_W-1:0]    enc_id_s;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               irq_req_r;
  logic               irq_req_nxt_s;
  logic [ID_W-1:0]    irq_id_r;
  logic [ID_W-1:0]    irq_id_nxt_s;
  logic               in_service_r;
  logic               in_service_nxt_s;

`ifdef INT_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_r;
  logic [NUM_SRC-1:0] sync2_r;

  // Two-flop synchronizer for asynchronous interrupt sources
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= Irq_In;
      sync2_r <= sync1_r;
    end
  end

  assign src_s = sync2_r;
`else
  assign src_s = Irq_In;
`endif

  assign real_s   = src_s ^ SRC_POLARITY;
  assign rise_s   = real_s & ~prev_r;
  assign active_s = pending_r & ~mask_r;

  int_prio_enc4 u_prio (
    .req (active_s),
    .any (enc_any_s),
    .id  (enc_id_s)
  );

  // Next-state and output decode for the IDLE -> REQ -> SERVICE handshake
  always_comb begin
    state_nxt_s      = state_r;
    irq_req_nxt_s    = irq_req_r;
    irq_id_nxt_s     = irq_id_r;
    in_service_nxt_s = in_service_r;
    clr_s            = 4'b0000;
    case (state_r)
      ST_IDLE: begin
        if (enc_any_s) begin
          state_nxt_s   = ST_REQ;
          irq_req_nxt_s = 1'b1;
          irq_id_nxt_s  = enc_id_s;
        end else begin
          state_nxt_s   = ST_IDLE;
          irq_req_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        // Mask is deliberately not consulted here so a late mask cannot withdraw the request
        if (Int_Ack) begin
          state_nxt_s      = ST_SERVICE;
          irq_req_nxt_s    = 1'b0;
          in_service_nxt_s = 1'b1;
          clr_s            = id_to_onehot(irq_id_r);
        end else begin
          state_nxt_s   = ST_REQ;
          irq_req_nxt_s = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (Int_Ret) begin
          state_nxt_s      = ST_IDLE;
          in_service_nxt_s = 1'b0;
        end else begin
          state_nxt_s      = ST_SERVICE;
          in_service_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        irq_req_nxt_s    = 1'b0;
        irq_id_nxt_s     = 2'd0;
        in_service_nxt_s = 1'b0;
      end
    endcase
  end

  // A fresh edge on the same cycle as its acknowledge keeps the bit pending
  always_comb begin
    pending_nxt_s = (pending_r & ~clr_s) | rise_s;
  end

  // Edge history, pending and mask registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prev_r    <= 4'b0000;
      pending_r <= 4'b0000;
      mask_r    <= MASK_RESET;
    end else begin
      prev_r    <= real_s;
      pending_r <= pending_nxt_s;
      if (Mask_Wr) begin
        mask_r <= Mask_Data;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // FSM state and registered CPU-facing outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      irq_req_r    <= 1'b0;
      irq_id_r     <= 2'd0;
      in_service_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      irq_req_r    <= irq_req_nxt_s;
      irq_id_r     <= irq_id_nxt_s;
      in_service_r <= in_service_nxt_s;
    end
  end

  assign Irq_Req    = irq_req_r;
  assign Irq_Id     = irq_id_r;
  assign In_Service = in_service_r;
  assign Pending    = pending_r;
  assign Mask       = mask_r;

endmodule

// File: tb/tb_int_ctrl_4src.sv
// Randomized plus directed bench for int_ctrl_4src with a scoreboard fed by a behavioural model.
module tb_int_ctrl_4src;

  localparam logic [3:0] POL = 4'b0001;
`ifdef INT_CTRL_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int EXTRA = 2;
`else
  localparam bit SYNC = 1'b0;
  localparam int EXTRA = 0;
`endif

  typedef struct packed {
    logic [3:0] pend;
    logic [3:0] mask;
    logic       req;
    logic [1:0] id;
    logic       svc;
  } snap_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Irq_In = POL;
  logic       Mask_Wr = 1'b0;
  logic [3:0] Mask_Data = 4'b0000;
  logic       Int_Ack = 1'b0;
  logic       Int_Ret = 1'b0;
  logic       Irq_Req;
  logic [1:0] Irq_Id;
  logic       In_Service;
  logic [3:0] Pending;
  logic [3:0] Mask;

  int n_cmp = 0;
  int n_err = 0;

  snap_t      exp_q[$];
  logic [1:0] req_q[$];

  // behavioural model: spec-level view of the controller
  logic [3:0] m_pend, m_mask, m_prev, m_s1, m_s2;
  int         m_st;   // 0 = idle, 1 = request, 2 = service
  logic [1:0] m_id;

  int_ctrl_4src #(.SRC_POLARITY(POL)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Irq_In     (Irq_In),
    .Mask_Wr    (Mask_Wr),
    .Mask_Data  (Mask_Data),
    .Int_Ack    (Int_Ack),
    .Int_Ret    (Int_Ret),
    .Irq_Req    (Irq_Req),
    .Irq_Id     (Irq_Id),
    .In_Service (In_Service),
    .Pending    (Pending),
    .Mask       (Mask)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    m_pend = 4'b0000;
    m_mask = 4'b1111;
    m_prev = 4'b0000;
    m_s1   = 4'b0000;
    m_s2   = 4'b0000;
    m_st   = 0;
    m_id   = 2'd0;
  endtask

  // advance the model across one rising edge using the inputs now being driven
  task automatic model_step(input logic [3:0] irq, input logic mwr, input logic [3:0] mdata,
                            input logic ack, input logic ret);
    logic [3:0] src, rl, rise, clr, eff;
    snap_t s;
    src  = SYNC ? m_s2 : irq;
    rl   = src ^ POL;
    rise = rl & ~m_prev;
    clr  = 4'b0000;
    eff  = m_pend & ~m_mask;
    if (m_st == 0) begin
      if (eff != 4'b0000) begin
        for (int i = 3; i >= 0; i--) if (eff[i]) m_id = 2'(i);
        m_st = 1;
        req_q.push_back(m_id);
      end
    end else if (m_st == 1) begin
      if (ack) begin
        clr[m_id] = 1'b1;
        m_st = 2;
      end
    end else begin
      if (ret) m_st = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mwr) m_mask = mdata;
    m_prev = rl;
    m_s2   = m_s1;
    m_s1   = irq;
    s.pend = m_pend;
    s.mask = m_mask;
    s.req  = (m_st == 1);
    s.id   = m_id;
    s.svc  = (m_st == 2);
    exp_q.push_back(s);
  endtask

  task automatic cycle(input logic [3:0] irq, input logic mwr, input logic [3:0] mdata,
                       input logic ack, input logic ret);
    @(negedge Clock);
    Reset     = 1'b0;
    Irq_In    = irq;
    Mask_Wr   = mwr;
    Mask_Data = mdata;
    Int_Ack   = ack;
    Int_Ret   = ret;
    model_step(irq, mwr, mdata, ack, ret);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(Irq_In, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic serve();
    idle(6);
    cycle(Irq_In, 1'b0, 4'b0000, 1'b1, 1'b0);
    idle(1);
    cycle(Irq_In, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  // asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic reset_pulse(input logic [3:0] irq);
    snap_t act;
    @(negedge Clock);
    #2;
    Reset   = 1'b1;
    Irq_In  = irq;
    Mask_Wr = 1'b0;
    Int_Ack = 1'b0;
    Int_Ret = 1'b0;
    #1;
    act = {Pending, Mask, Irq_Req, Irq_Id, In_Service};
    n_cmp++;
    if (act !== {4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got pend=%b mask=%b req=%b id=%0d svc=%b, need pend=0000 mask=1111 req=0 id=0 svc=0",
               Pending, Mask, Irq_Req, Irq_Id, In_Service);
    end
    model_reset();
  endtask

  // monitor: compares the register view each cycle and request ids on each new request
  initial begin
    snap_t e, act;
    logic [1:0] eid;
    logic req_d;
    req_d = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {Pending, Mask, Irq_Req, Irq_Id, In_Service};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL state @%0t: got pend=%b mask=%b req=%b id=%0d svc=%b, need pend=%b mask=%b req=%b id=%0d svc=%b",
                   $time, act.pend, act.mask, act.req, act.id, act.svc, e.pend, e.mask, e.req, e.id, e.svc);
        end
      end
      if (Irq_Req === 1'b1 && req_d === 1'b0) begin
        n_cmp++;
        if (req_q.size() == 0) begin
          n_err++;
          $display("FAIL req_id @%0t: got unexpected request id=%0d, need no request", $time, Irq_Id);
        end else begin
          eid = req_q.pop_front();
          if (Irq_Id !== eid) begin
            n_err++;
            $display("FAIL req_id @%0t: got id=%0d, need id=%0d", $time, Irq_Id, eid);
          end
        end
      end
      req_d = Irq_Req;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cur;
    model_reset();
    reset_pulse(POL);

    // unmask all, single edge on source 2
    cycle(POL, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(POL | 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    serve();

    // simultaneous edges on sources 3 and 1: id 1 first, then 3
    cycle(POL | 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    serve();
    serve();

    // masked source 0 still pends (active-low pulse), unmasking raises it
    cycle(POL, 1'b1, 4'b0001, 1'b0, 1'b0);
    cycle(POL ^ 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(5);
    cycle(POL, 1'b1, 4'b0000, 1'b0, 1'b0);
    serve();

    // new edge on serviced source coincident with Int_Ack keeps it pending
    cycle(POL | 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(5);
    for (int i = 0; i < EXTRA; i++) cycle(POL | 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(POL | 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(2);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b1);
    serve();

    // ack/ret outside their states are ignored; mask write during request
    cycle(POL, 1'b0, 4'b0000, 1'b1, 1'b1);
    cycle(POL | 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(5);
    cycle(POL, 1'b1, 4'b1111, 1'b0, 1'b1);
    idle(2);
    cycle(POL, 1'b0, 4'b0000, 1'b1, 1'b0);
    idle(2);

    // reset during service with active-low source 0 held active across release
    reset_pulse(POL ^ 4'b0001);
    cycle(POL ^ 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(3);
    cycle(POL ^ 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
    serve();
    cycle(POL, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(3);

    // randomized traffic
    cur = POL;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3, 0) == 0) cur = 4'($urandom_range(15, 0));
      cycle(cur, ($urandom_range(15, 0) == 0), 4'($urandom_range(15, 0)),
            ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
      if (n == 1500) begin
        reset_pulse(cur);
      end
    end

    @(posedge Clock);
    #2;
    n_cmp++;
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d state and %0d request entries left, need 0 and 0",
               exp_q.size(), req_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
